// File: rtl/aes128_round_ctrl_if.sv
// Handshake and datapath-control bundle between the AES-128 round controller
// (slave side) and the requester/datapath (master side).
interface aes128_round_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       ld_text;
    logic       ld_key;
    logic       rnd_en;
    logic       mc_en;
    logic [7:0] rcon;
    logic [3:0] round;
    logic       busy;

    modport master (
        output in_valid, out_ready,
        input  in_ready, out_valid, ld_text, ld_key, rnd_en, mc_en, rcon, round, busy
    );

    modport slave (
        input  in_valid, out_ready,
        output in_ready, out_valid, ld_text, ld_key, rnd_en, mc_en, rcon, round, busy
    );
endinterface

// File: rtl/aes128_round_ctrl.sv
// AES-128 iterative round controller: sequences load, 9 full rounds and a final
// round, then holds the ciphertext until taken. Optional macro AES_CTRL_BLKCNT_EN
// adds a wrapping completed-block counter on port blk_cnt.
module aes128_round_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    aes128_round_ctrl_if.slave    ctrl
`ifdef AES_CTRL_BLKCNT_EN
    ,
    output logic [CNT_W-1:0]      blk_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [7:0] rcon_q, rcon_d;
    logic       in_ready_s;
    logic       accept_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Back-to-back accept is allowed only in the cycle the finished block leaves.
    assign in_ready_s = rst && ((state_q == S_IDLE) ||
                                ((state_q == S_DONE) && ctrl.out_ready));
    assign accept_s   = ctrl.in_valid && in_ready_s;

    // Next-state, round index and round-constant generation.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        case (state_q)
            S_IDLE: begin
                round_d = 4'd0;
                rcon_d  = 8'h00;
                if (accept_s) begin
                    state_d = S_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                state_d = S_ROUND;
                round_d = 4'd1;
                rcon_d  = 8'h01;
            end
            S_ROUND: begin
                round_d = round_q + 4'd1;
                rcon_d  = xtime(rcon_q);
                if (round_q == 4'd9) begin
                    state_d = S_FINAL;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_FINAL: begin
                state_d = S_DONE;
                round_d = 4'd10;
                rcon_d  = 8'h00;
            end
            S_DONE: begin
                if (ctrl.out_ready) begin
                    round_d = 4'd0;
                    rcon_d  = 8'h00;
                    if (ctrl.in_valid) begin
                        state_d = S_INIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                round_d = 4'd0;
                rcon_d  = 8'h00;
            end
        endcase
    end

    // State, round and rcon registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            rcon_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    assign ctrl.in_ready  = in_ready_s;
    assign ctrl.out_valid = (state_q == S_DONE);
    assign ctrl.ld_text   = (state_q == S_INIT);
    assign ctrl.ld_key    = (state_q == S_INIT);
    assign ctrl.rnd_en    = (state_q == S_ROUND) || (state_q == S_FINAL);
    assign ctrl.mc_en     = (state_q == S_ROUND);
    assign ctrl.rcon      = rcon_q;
    assign ctrl.round     = round_q;
    assign ctrl.busy      = (state_q != S_IDLE);

`ifdef AES_CTRL_BLKCNT_EN
    logic [CNT_W-1:0] blk_cnt_q;

    // Completed-block counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst) begin
            blk_cnt_q <= {CNT_W{1'b0}};
        end else if ((state_q == S_DONE) && ctrl.out_ready) begin
            blk_cnt_q <= blk_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            blk_cnt_q <= blk_cnt_q;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Scoreboard bench for aes128_round_ctrl: a behavioural AES datapath driven by
// the controller strobes is checked against a reference AES-128 encryption.
module tb_aes128_round_ctrl;
`ifdef AES_CTRL_BLKCNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aes128_round_ctrl_if bus ();
    logic [127:0] pt, key;
`ifdef AES_CTRL_BLKCNT_EN
    logic [CNT_W-1:0] blk_cnt;
    int blk_m;
`endif

    aes128_round_ctrl #(.CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
`ifdef AES_CTRL_BLKCNT_EN
        ,
        .blk_cnt (blk_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference AES-128 ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, s, b;
        r = 8'h01;
        s = x;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        b = (x == 8'h00) ? 8'h00 : r;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk, input logic mc);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
        if (mc) begin
            for (int c = 0; c < 4; c++) begin
                a0 = o[127-32*c -: 8];
                a1 = o[119-32*c -: 8];
                a2 = o[111-32*c -: 8];
                a3 = o[103-32*c -: 8];
                o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        return o ^ rk;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {rk[23:0], rk[31:24]};
        t  = {sbox(t[31:24]) ^ rc, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        w0 = rk[127:96] ^ t;
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] s, rk;
        logic [7:0] rc;
        s  = p ^ k;
        rk = k;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            rk = key_step(rk, rc);
            s  = aes_round(s, rk, r < 10);
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
        end
        return s;
    endfunction

    // ---------------- model + scoreboard ----------------
    typedef struct {
        logic [127:0] ct;
        int           acc;
    } exp_t;

    exp_t         sbq[$];
    int           phase = 0;   // 0 idle, 1..11 cycles since accept, 12 holding output
    int           cyc = 0;
    int           acc_cnt = 0;
    logic         chk_en = 1'b0;
    logic [127:0] dp_pt, dp_key, st, rk;
    logic [7:0]   rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    initial begin
        exp_t e;
        logic acc;
        dp_pt = '0; dp_key = '0; st = '0; rk = '0;
`ifdef AES_CTRL_BLKCNT_EN
        blk_m = 0;
`endif
        forever begin
            @(posedge clk);
            cyc++;
            if (bus.ld_text) begin
                st = dp_pt ^ dp_key;
                rk = dp_key;
            end else if (bus.rnd_en) begin
                rk = key_step(rk, bus.rcon);
                st = aes_round(st, rk, bus.mc_en);
            end
            if (!rst) begin
                phase = 0;
                sbq.delete();
`ifdef AES_CTRL_BLKCNT_EN
                blk_m = 0;
`endif
            end else begin
                acc = bus.in_valid && (phase == 0 || (phase == 12 && bus.out_ready));
`ifdef AES_CTRL_BLKCNT_EN
                if (phase == 12 && bus.out_ready) blk_m = (blk_m + 1) % (1 << CNT_W);
`endif
                if (acc) begin
                    dp_pt  = pt;
                    dp_key = key;
                    e.ct   = (pt == FIPS_PT && key == FIPS_KEY) ? FIPS_CT : aes_ref(pt, key);
                    e.acc  = cyc - 1;
                    sbq.push_back(e);
                    acc_cnt++;
                    phase = 1;
                end else if (phase == 12) begin
                    phase = bus.out_ready ? 0 : 12;
                end else if (phase != 0) begin
                    phase++;
                end
            end
            chk_en = 1'b1;
        end
    end

    // Monitor: per-cycle control outputs, latency and ciphertext scoreboard.
    logic prev_ov = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("in_ready", bus.in_ready, rst && (phase == 0 || (phase == 12 && bus.out_ready)));
                chk("out_valid", bus.out_valid, phase == 12);
                chk("ld_text", bus.ld_text, phase == 1);
                chk("ld_key", bus.ld_key, phase == 1);
                chk("rnd_en", bus.rnd_en, phase >= 2 && phase <= 11);
                chk("mc_en", bus.mc_en, phase >= 2 && phase <= 10);
                chk("rcon", bus.rcon, (phase >= 2 && phase <= 11) ? rc_tab[phase-2] : 8'h00);
                chk("round", bus.round, (phase == 0) ? 0 : ((phase >= 11) ? 10 : phase - 1));
                chk("busy", bus.busy, phase != 0);
`ifdef AES_CTRL_BLKCNT_EN
                chk("blk_cnt", blk_cnt, blk_m);
`endif
                if (bus.out_valid && !prev_ov) begin
                    chk("sb_nonempty", sbq.size() != 0, 1'b1);
                    if (sbq.size() != 0) chk("latency", cyc - sbq[0].acc, 12);
                end
                if (bus.out_valid && bus.out_ready) begin
                    chk("sb_nonempty", sbq.size() != 0, 1'b1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        chk("ciphertext", st, e.ct);
                    end
                end
                prev_ov = bus.out_valid;
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [127:0] p, input logic [127:0] k);
        int start;
        start        = acc_cnt;
        pt           = p;
        key          = k;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40 && acc_cnt == start; i++) begin
            @(posedge clk);
            #2;
        end
        chk("accept_timeout", acc_cnt != start, 1'b1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        pt  = '0;
        key = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // FIPS-197 vector
        send(FIPS_PT, FIPS_KEY);
        bus.in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2;

        // back-to-back blocks with in_valid held while busy
        send(rnd128(), rnd128());
        send(rnd128(), rnd128());
        send(rnd128(), rnd128());
        bus.in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2;

        // consumer stall at DONE with a pending request
        bus.out_ready = 1'b0;
        send(rnd128(), rnd128());
        pt  = rnd128();
        key = rnd128();
        for (int i = 0; i < 30 && !bus.out_valid; i++) begin
            @(posedge clk);
            #2;
        end
        repeat (5) @(posedge clk);
        #2 bus.out_ready = 1'b1;
        send(pt, key);
        bus.in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2;

        // reset during round 5, then a fresh block
        send(rnd128(), rnd128());
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && phase != 6; i++) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        send(rnd128(), rnd128());
        bus.in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            pt            = rnd128();
            key           = rnd128();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #2;
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (30) @(posedge clk);
        #2;
        chk("sb_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes128_round_ctrl.md
AES128_ROUND_CTRL -- requirements
Module: aes128_round_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of completed-block counter (used only when AES_CTRL_BLKCNT_EN is defined).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  requester has plaintext/key ready on datapath inputs.
REQ-005 SHALL have port: in_ready  output  1  controller accepts a block this cycle.
REQ-006 SHALL have port: out_valid  output  1  datapath state register holds finished ciphertext.
REQ-007 SHALL have port: out_ready  input  1  consumer takes ciphertext this cycle.
REQ-008 SHALL have port: ld_text  output  1  datapath loads plain_text ^ key into state register (round-0 AddRoundKey).
REQ-009 SHALL have port: ld_key  output  1  datapath loads cipher key into round-key register.
REQ-010 SHALL have port: rnd_en  output  1  datapath performs one round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey) and advances round key.
REQ-011 SHALL have port: mc_en  output  1  MixColumns included in current round.
REQ-012 SHALL have port: rcon  output  8  round constant for key-schedule step of current round.
REQ-013 SHALL have port: round  output  4  current round index 0..10.
REQ-014 SHALL have port: busy  output  1  block in flight (state not IDLE).
REQ-015 SHALL have port: blk_cnt  output  CNT_W  count of completed output handshakes (present only with AES_CTRL_BLKCNT_EN).

Function
REQ-016 SHALL implement FSM states IDLE, INIT, ROUND, FINAL, DONE; all outputs except in_ready SHALL decode from registered state only.
REQ-017 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready); accept = in_valid and in_ready.
REQ-018 SHALL transition IDLE->INIT on accept; otherwise stay IDLE.
REQ-019 INIT SHALL last one cycle: ld_text=1, ld_key=1, round=0, rcon=8'h00, rnd_en=0; next ROUND with round=1.
REQ-020 ROUND SHALL assert rnd_en=1, mc_en=1 each cycle for rounds 1..9, incrementing round each cycle; after round 9 next FINAL.
REQ-021 FINAL SHALL last one cycle: rnd_en=1, mc_en=0, round=10; next DONE.
REQ-022 rcon SHALL equal 01,02,04,08,10,20,40,80,1B,36 for rounds 1..10, generated by GF(2^8) xtime (shift left, XOR 8'h1B if MSB set), reset to 8'h01 at INIT.
REQ-023 DONE SHALL hold out_valid=1 with round=10 and all datapath strobes 0 until out_ready=1.
REQ-024 On DONE with out_ready=1: if in_valid=1 SHALL go directly to INIT (back-to-back, no bubble), else IDLE.
REQ-025 Latency: accept at cycle T -> out_valid first high at T+12; throughput one block per 12 cycles with out_ready held high.
REQ-026 in_valid while busy and not in DONE-with-out_ready SHALL be ignored; no state or counter change.
REQ-027 ld_text, ld_key, rnd_en SHALL never be high simultaneously with out_valid.
REQ-028 Illegal/unreachable state encodings SHALL return to IDLE next cycle.

Reset
REQ-029 rst=0 at a rising edge SHALL force IDLE, round=0, rcon=8'h00, out_valid=0, busy=0, all strobes 0, blk_cnt=0, regardless of state (including mid-round or DONE); in-flight block discarded.
REQ-030 in_ready SHALL be 0 while rst=0 and 1 in first cycle after release.

Configuration
REQ-031 With macro AES_CTRL_BLKCNT_EN defined, blk_cnt port and counter SHALL exist, incrementing by 1 on each out_valid and out_ready cycle, wrapping 2^CNT_W-1 -> 0.
REQ-032 Without AES_CTRL_BLKCNT_EN, blk_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset release, in_valid=1 at T -> ld_text=ld_key=1 at T+1, rnd_en rounds 1..9 with mc_en=1, round 10 mc_en=0, out_valid at T+12; with FIPS-197 vector (pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c) on reference datapath -> 3925841d02dc09fbdc118597196a0b32.
REQ-034 Monitor rcon over one block -> 00, then 01,02,04,08,10,20,40,80,1B,36 in rounds 1..10.
REQ-035 out_ready=0 for 5 cycles at DONE with in_valid=1 -> out_valid held, in_ready=0, no INIT; out_ready=1 -> INIT next cycle, second block out_valid 12 cycles after.
REQ-036 rst=0 asserted during round 5 -> next cycle IDLE, out_valid=0, round=0; new block afterwards completes normally.
REQ-037 AES_CTRL_BLKCNT_EN, CNT_W=2, 5 completed blocks -> blk_cnt sequence 1,2,3,0,1.
